iir_biquad_cascade_axis: RTL and testbench

//  Parametrised cascade of NUM_SECTIONS DF1 biquads behind one time-shared multiply-accumulate unit.
//  - Coefficients are loaded at run time.
//  - Full AXI4-Stream backpressure: no sample is dropped.
//  - Saturates between sections and at the output.

---
 rtl/iir_cascade_pkg.sv | 33 +++
 rtl/iir_mac_unit.sv | 34 +++
 rtl/iir_biquad_cascade_axis.sv | 156 +++++++++++++++
 tb/tb_iir_biquad_cascade_axis.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_cascade_pkg.sv
// Shared definitions for the biquad cascade: tap order, FSM encoding and the
// round-half-up / saturate helper used at every section output.
package iir_cascade_pkg;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    STORE,
    OUT
  } state_t;

  // Rounds a fixed-point accumulator down by 'scale' bits and clamps it to a signed 'width'-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int scale,
                                                   input int width);
    logic signed [63:0] rounded;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rounded = (acc + (64'sd1 <<< (scale - 1))) >>> scale;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (rounded > hi) return hi;
    if (rounded < lo) return lo;
    return rounded;
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Single-stage signed multiply-accumulate: acc <= (clr ? 0 : acc) +/- a*b.
// Sized to fit one DSP48E1 (25x18 multiplier, 48-bit accumulator).
module iir_mac_unit #(
  parameter int A_WIDTH   = 25,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic                        sub,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]       prod_ext;
  logic signed [ACC_WIDTH-1:0]       base;

  assign prod     = a * b;
  assign prod_ext = ACC_WIDTH'(prod);
  assign base     = clr ? '0 : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? (base - prod_ext) : (base + prod_ext);
    end
  end

endmodule

// File: rtl/iir_biquad_cascade_axis.sv
// Cascade of DF1 biquads sharing one MAC; each section takes 5 MAC cycles plus
// one STORE cycle, with AXI4-Stream handshakes on both sides.
module iir_biquad_cascade_axis
  import iir_cascade_pkg::*;
#(
  parameter int NUM_SECTIONS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int COEFF_WIDTH  = 25,
  parameter int SCALE_FACTOR = 23,
  parameter int ACC_WIDTH    = 48
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  input  logic signed [DATA_WIDTH-1:0]           s_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic signed [DATA_WIDTH-1:0]           m_axis_tdata,
  input  logic                                   cfg_we,
  input  logic [$clog2(NUM_SECTIONS*5)-1:0]      cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0]          cfg_data,
  output logic                                   cfg_ready,
  input  logic                                   clear
);

  localparam int NUM_COEFFS = NUM_SECTIONS * 5;
  localparam int ADDR_WIDTH = $clog2(NUM_COEFFS);
  localparam int SEC_WIDTH  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam logic [SEC_WIDTH-1:0] LAST_SEC = SEC_WIDTH'(NUM_SECTIONS - 1);
  localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(64'sd1 <<< SCALE_FACTOR);

  state_t                        state, next_state;
  logic [SEC_WIDTH-1:0]          sec;
  logic [2:0]                    tap;
  logic signed [DATA_WIDTH-1:0]  cur_x, out_data, y_sat, mul_x;
  logic signed [COEFF_WIDTH-1:0] mul_c;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [ADDR_WIDTH-1:0]         coef_idx;
  logic                          in_idle, cfg_hit;

  logic signed [COEFF_WIDTH-1:0] coef [NUM_COEFFS];
  logic signed [DATA_WIDTH-1:0]  x1_h [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  x2_h [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  y1_h [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  y2_h [NUM_SECTIONS];

  assign in_idle       = (state == IDLE);
  assign s_axis_tready = in_idle;
  assign cfg_ready     = in_idle;
  assign m_axis_tvalid = (state == OUT);
  assign m_axis_tdata  = out_data;
  assign cfg_hit       = in_idle && cfg_we && ({1'b0, cfg_addr} < (ADDR_WIDTH + 1)'(NUM_COEFFS));
  assign coef_idx      = ADDR_WIDTH'(sec * 5 + tap);
  assign y_sat         = DATA_WIDTH'(round_sat(64'(acc), SCALE_FACTOR, DATA_WIDTH));

  always_comb begin
    mul_c = coef[coef_idx];
    mul_x = cur_x;
    case (tap)
      TAP_B1:  mul_x = x1_h[sec];
      TAP_B2:  mul_x = x2_h[sec];
      TAP_A1:  mul_x = y1_h[sec];
      TAP_A2:  mul_x = y2_h[sec];
      default: mul_x = cur_x;
    endcase
  end

  iir_mac_unit #(
    .A_WIDTH  (COEFF_WIDTH),
    .B_WIDTH  (DATA_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .en (state == MAC),
    .clr(tap == TAP_B0),
    .sub((tap == TAP_A1) || (tap == TAP_A2)),
    .a  (mul_c),
    .b  (mul_x),
    .acc(acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (s_axis_tvalid) next_state = MAC;
      MAC:     if (tap == TAP_A2) next_state = STORE;
      STORE:   next_state = (sec == LAST_SEC) ? OUT : MAC;
      OUT:     if (m_axis_tready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Coefficient writes land in IDLE, so a coincident sample already sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFFS; i++)
        coef[i] <= (3'(i % 5) == TAP_B0) ? UNITY : '0;
    end else if (cfg_hit) begin
      coef[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec      <= '0;
      tap      <= TAP_B0;
      cur_x    <= '0;
      out_data <= '0;
      for (int i = 0; i < NUM_SECTIONS; i++) begin
        x1_h[i] <= '0;
        x2_h[i] <= '0;
        y1_h[i] <= '0;
        y2_h[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
              x1_h[i] <= '0;
              x2_h[i] <= '0;
              y1_h[i] <= '0;
              y2_h[i] <= '0;
            end
          end
          if (s_axis_tvalid) begin
            cur_x <= s_axis_tdata;
            sec   <= '0;
            tap   <= TAP_B0;
          end
        end
        MAC: tap <= (tap == TAP_A2) ? TAP_B0 : tap + 3'd1;
        STORE: begin
          // The saturated section output feeds both the y history and the next section.
          x2_h[sec] <= x1_h[sec];
          x1_h[sec] <= cur_x;
          y2_h[sec] <= y1_h[sec];
          y1_h[sec] <= y_sat;
          cur_x     <= y_sat;
          tap       <= TAP_B0;
          if (sec == LAST_SEC) out_data <= y_sat;
          else                 sec      <= sec + SEC_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade_axis.sv
// Randomised and directed bench for the biquad cascade against a plain
// arithmetic model of the cascade kept in the bench.
module tb_iir_biquad_cascade_axis;

  localparam int NS  = 4;
  localparam int DW  = 16;
  localparam int CW  = 25;
  localparam int SF  = 23;
  localparam int AW  = 48;
  localparam int NC  = NS * 5;
  localparam int ADW = $clog2(NC);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_axis_tvalid, s_axis_tready;
  logic signed [DW-1:0] s_axis_tdata;
  logic                 m_axis_tvalid, m_axis_tready;
  logic signed [DW-1:0] m_axis_tdata;
  logic                 cfg_we, cfg_ready, clear;
  logic [ADW-1:0]       cfg_addr;
  logic signed [CW-1:0] cfg_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int out_count = 0;
  int hs_edge = 0;

  longint mcoef [NC];
  longint mx1 [NS];
  longint mx2 [NS];
  longint my1 [NS];
  longint my2 [NS];
  longint exp_q [$];
  bit prev_valid = 1'b0;
  bit prev_mhs = 1'b0;
  logic signed [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_biquad_cascade_axis #(
    .NUM_SECTIONS(NS),
    .DATA_WIDTH  (DW),
    .COEFF_WIDTH (CW),
    .SCALE_FACTOR(SF),
    .ACC_WIDTH   (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .clear        (clear)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for handshake", name);
  endtask

  function automatic void model_clear_history();
    for (int s = 0; s < NS; s++) begin
      mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) mcoef[i] = ((i % 5) == 0) ? (longint'(1) <<< SF) : 0;
    model_clear_history();
    exp_q.delete();
  endfunction

  function automatic longint sat_round(input longint acc);
    longint r;
    r = (acc + (longint'(1) <<< (SF - 1))) >>> SF;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Difference equation per section, saturated output feeding the next section.
  function automatic longint model_run(input longint x_in);
    longint x, acc, y;
    x = x_in;
    y = 0;
    for (int s = 0; s < NS; s++) begin
      acc = mcoef[s*5] * x + mcoef[s*5+1] * mx1[s] + mcoef[s*5+2] * mx2[s]
          - mcoef[s*5+3] * my1[s] - mcoef[s*5+4] * my2[s];
      y = sat_round(acc);
      mx2[s] = mx1[s]; mx1[s] = x;
      my2[s] = my1[s]; my1[s] = y;
      x = y;
    end
    return y;
  endfunction

  // Mid-cycle observer: updates the model for the upcoming edge and checks outputs.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      prev_valid = 1'b0;
      prev_mhs = 1'b0;
    end else begin
      if (cfg_we && cfg_ready && int'(cfg_addr) < NC) mcoef[cfg_addr] = longint'(cfg_data);
      if (clear && cfg_ready) model_clear_history();
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back(model_run(longint'(s_axis_tdata)));
        hs_count++;
        hs_edge = cyc + 1;
      end
      if (prev_mhs) begin
        check("idle_after_out_valid", m_axis_tvalid, 0);
        check("idle_after_out_ready", s_axis_tready, 1);
      end
      if (m_axis_tvalid) begin
        check("tready_low_in_out", s_axis_tready, 0);
        if (!prev_valid) check("latency", cyc - hs_edge, 6 * NS);
        else if (!prev_mhs) check("data_stable", m_axis_tdata, prev_data);
      end
      prev_mhs = m_axis_tvalid && m_axis_tready;
      if (prev_mhs) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0d expected no output", m_axis_tdata);
        end else begin
          check("model_output", m_axis_tdata, exp_q.pop_front());
        end
      end
      prev_valid = m_axis_tvalid;
      prev_data = m_axis_tdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int val);
    cfg_we = 1'b1;
    cfg_addr = ADW'(addr);
    cfg_data = CW'(val);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send_sample(input int x, input bit with_clear);
    bit ok;
    ok = 1'b0;
    s_axis_tdata = DW'(x);
    s_axis_tvalid = 1'b1;
    clear = with_clear;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    s_axis_tvalid = 1'b0;
    clear = 1'b0;
    if (!ok) fail_timeout("send_sample");
  endtask

  task automatic get_output(input bit has_exp, input int exp, input string name);
    bit got;
    got = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        got = 1'b1;
        if (has_exp) check(name, m_axis_tdata, exp);
        break;
      end
    end
    step();
    m_axis_tready = 1'b0;
    if (!got) fail_timeout(name);
  endtask

  initial begin
    int prev_cnt, guard, base_in, oc, v;
    bit ok;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_s_tready", s_axis_tready, 1);
    check("reset_m_tvalid", m_axis_tvalid, 0);
    check("reset_m_tdata", m_axis_tdata, 0);
    check("reset_cfg_ready", cfg_ready, 1);
    step();

    // Pass-through defaults; out-of-range write must be ignored.
    cfg_write(25, 12345);
    send_sample(1000, 1'b0);
    get_output(1'b1, 1000, "passthrough_1000");

    // Rounding with b0 = 0.5 in section 0.
    cfg_write(0, 1 << 22);
    send_sample(3, 1'b0);
    get_output(1'b1, 2, "round_3");
    send_sample(-3, 1'b0);
    get_output(1'b1, -1, "round_neg3");
    send_sample(1000, 1'b0);
    get_output(1'b1, 500, "round_1000");

    // Saturation with gain just under 2 in every section.
    for (int s = 0; s < NS; s++) cfg_write(s * 5, (1 << 24) - 1);
    send_sample(20000, 1'b0);
    get_output(1'b1, 32767, "sat_pos");
    send_sample(-20000, 1'b0);
    get_output(1'b1, -32768, "sat_neg");

    // First-order recursion y = x + 0.5*y1 in section 0.
    for (int s = 0; s < NS; s++) cfg_write(s * 5, 1 << 23);
    cfg_write(3, -(1 << 22));
    clear = 1'b1;
    step();
    clear = 1'b0;
    send_sample(1024, 1'b0);
    get_output(1'b1, 1024, "impulse_0");
    send_sample(0, 1'b0);
    get_output(1'b1, 512, "impulse_1");
    send_sample(0, 1'b0);
    get_output(1'b1, 256, "impulse_2");
    send_sample(0, 1'b1);
    get_output(1'b1, 0, "clear_with_sample");

    // Hold the output under backpressure for 10 cycles.
    send_sample(500, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    if (!ok) fail_timeout("bp_wait");
    s_axis_tdata = 16'sd77;
    s_axis_tvalid = 1'b1;
    repeat (10) step();
    s_axis_tvalid = 1'b0;
    get_output(1'b1, 500, "bp_hold_value");

    // Random traffic, coefficient writes and clears.
    base_in = hs_count;
    guard = 0;
    while ((hs_count - base_in < 200 || exp_q.size() != 0) && guard < 20000) begin
      if (!s_axis_tvalid && hs_count - base_in < 200 && $urandom_range(0, 2) != 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata = DW'($urandom);
        clear = ($urandom_range(0, 15) == 0);
      end
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1;
        v = int'($urandom_range(0, NC - 1));
        cfg_addr = ADW'(v);
        if (v % 5 < 3) cfg_data = CW'(int'($urandom_range(0, 1 << 24)) - (1 << 23));
        else           cfg_data = CW'(int'($urandom_range(0, 1 << 23)) - (1 << 22));
      end else begin
        cfg_we = 1'b0;
      end
      prev_cnt = hs_count;
      step();
      guard++;
      if (s_axis_tvalid && hs_count != prev_cnt) begin
        s_axis_tvalid = 1'b0;
        clear = 1'b0;
      end
    end
    s_axis_tvalid = 1'b0;
    clear = 1'b0;
    cfg_we = 1'b0;
    m_axis_tready = 1'b0;
    if (guard >= 20000) fail_timeout("random_phase");
    check("random_samples_sent", hs_count - base_in, 200);
    check("random_queue_drained", exp_q.size(), 0);
    step();

    // Reset during a computation drops the sample and restores coefficients.
    cfg_write(0, 1 << 22);
    send_sample(1000, 1'b0);
    repeat (9) step();
    rst = 1'b1;
    step();
    check("midrst_s_tready", s_axis_tready, 1);
    check("midrst_m_tvalid", m_axis_tvalid, 0);
    check("midrst_m_tdata", m_axis_tdata, 0);
    check("midrst_cfg_ready", cfg_ready, 1);
    step();
    rst = 1'b0;
    oc = out_count;
    m_axis_tready = 1'b1;
    repeat (40) step();
    m_axis_tready = 1'b0;
    check("no_output_after_rst", out_count - oc, 0);
    send_sample(1000, 1'b0);
    get_output(1'b1, 1000, "coef_reset_passthrough");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
